// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and bit-counter sizing.
package serial_adder_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } state_t;

  // Counter must be able to hold WIDTH itself, hence WIDTH+1 codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
// start is a level request taken only when the adder is idle; done is a one-cycle
// pulse during which sum/cout are fresh (they then hold until the next done).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder cell used once per clock by the serial adder.
module fulladder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell with a registered carry, LSB first,
// one result every WIDTH+2 cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_if.slave       bus,
  output state_t              o_dbg_state
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_psum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_psum_next;

  fulladder u_fa (
    .i_a (r_a[0]),
    .i_b (r_b[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_co)
  );

  // New sum bit enters at the MSB so bit 0 lands in place after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_psum_w1
      assign w_psum_next = w_s;
    end else begin : g_psum_wn
      assign w_psum_next = {w_s, r_psum[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_psum  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_co;
          r_psum  <= w_psum_next;
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum   <= w_psum_next;
            r_cout  <= w_co;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.sum     = r_sum;
  assign bus.cout    = r_cout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: WIDTH=8 directed cases plus an exhaustive WIDTH=2 sweep.
module tb_serial_adder;
  import serial_adder_pkg::*;

  logic   clk;
  logic   rst8_n;
  logic   rst2_n;
  state_t dbg8;
  state_t dbg2;

  serial_adder_if #(.WIDTH(8)) bus8 ();
  serial_adder_if #(.WIDTH(2)) bus2 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(bus8), .o_dbg_state(dbg8));
  serial_adder #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(bus2), .o_dbg_state(dbg2));

  // clock/reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int done8_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Timeline model: t = edges since acceptance, -1 when idle.
  logic [8:0] exp8_q[$];
  logic [2:0] exp2_q[$];
  int         t8 = -1;
  int         t2 = -1;
  logic [8:0] res8, out8;
  logic [2:0] res2, out2;

  always @(posedge clk or negedge rst8_n) begin
    if (!rst8_n) begin
      t8 <= -1; out8 <= '0;
    end else if (t8 < 0) begin
      if (bus8.start) begin
        res8 <= {1'b0, bus8.a} + {1'b0, bus8.b} + {8'd0, bus8.cin};
        t8   <= 0;
      end
    end else if (t8 == 8) begin
      t8 <= -1;
    end else begin
      t8 <= t8 + 1;
      if (t8 == 7) begin
        out8 <= res8;
        exp8_q.push_back(res8);
      end
    end
  end

  always @(posedge clk or negedge rst2_n) begin
    if (!rst2_n) begin
      t2 <= -1; out2 <= '0;
    end else if (t2 < 0) begin
      if (bus2.start) begin
        res2 <= {1'b0, bus2.a} + {1'b0, bus2.b} + {2'd0, bus2.cin};
        t2   <= 0;
      end
    end else if (t2 == 2) begin
      t2 <= -1;
    end else begin
      t2 <= t2 + 1;
      if (t2 == 1) begin
        out2 <= res2;
        exp2_q.push_back(res2);
      end
    end
  end

  // scoreboard / per-cycle compare
  always @(negedge clk) begin
    check("w8_cycle", {bus8.busy, bus8.done, bus8.cout, bus8.sum},
          {(t8 >= 0 && t8 < 8), (t8 == 8), out8});
    check("w2_cycle", {bus2.busy, bus2.done, bus2.cout, bus2.sum},
          {(t2 >= 0 && t2 < 2), (t2 == 2), out2});
    if (bus8.done) begin
      done8_cnt <= done8_cnt + 1;
      if (exp8_q.size() == 0) check("sb8_unexpected_done", 1, 0);
      else check("sb8", {bus8.cout, bus8.sum}, exp8_q.pop_front());
    end
    if (bus2.done) begin
      if (exp2_q.size() == 0) check("sb2_unexpected_done", 1, 0);
      else check("sb2", {bus2.cout, bus2.sum}, exp2_q.pop_front());
    end
  end

  // driver tasks
  task automatic wait_done8(input string nm, input logic [8:0] exp_res, input int exp_lat);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus8.done) begin
        seen = 1;
        check(nm, {bus8.cout, bus8.sum}, exp_res);
        check({nm, "_lat"}, i, exp_lat);
        break;
      end
      @(negedge clk);
    end
    if (!seen) check({nm, "_timeout"}, 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic [8:0] exp_res, input string nm);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8(nm, exp_res, 8);
  endtask

  initial begin
    int d0;
    int last_cyc;
    bit seen;
    logic [4:0] kk;
    logic [2:0] exp_w2;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
    rst8_n = 1'b1; rst2_n = 1'b1;
    #1;
    rst8_n = 1'b0; rst2_n = 1'b0;
    bus8.start = 1'b1; bus2.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus8.a = 8'($urandom_range(0, 255)); bus8.b = 8'($urandom_range(0, 255));
      bus8.cin = 1'($urandom_range(0, 1));
      bus2.a = 2'($urandom_range(0, 3)); bus2.b = 2'($urandom_range(0, 3));
      @(negedge clk);
      check("reset_w8", {bus8.busy, bus8.done, bus8.cout, bus8.sum}, 0);
      check("reset_w2", {bus2.busy, bus2.done, bus2.cout, bus2.sum}, 0);
    end
    bus8.start = 1'b0; bus2.start = 1'b0;
    rst8_n = 1'b1; rst2_n = 1'b1;
    repeat (2) @(negedge clk);

    run8(8'h5A, 8'h3C, 1'b0, {1'b0, 8'h96}, "add_5a_3c");
    run8(8'hFF, 8'h01, 1'b0, {1'b1, 8'h00}, "carry_ff_01");
    run8(8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF}, "carry_ff_ff_c1");
    run8(8'h00, 8'h00, 1'b1, {1'b0, 8'h01}, "cin_only");

    // start during SHIFT must be ignored
    d0 = done8_cnt;
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h10; bus8.b = 8'h20; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (2) @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
    @(negedge clk);
    bus8.start = 1'b0;
    wait_done8("ignored_start", {1'b0, 8'h30}, 5);
    repeat (12) @(negedge clk);
    #1;
    check("ignored_start_one_done", done8_cnt - d0, 1);

    // reset in the middle of SHIFT
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'h11; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst8_n = 1'b0;
    #1;
    check("rst_mid_outputs", {bus8.busy, bus8.done, bus8.cout, bus8.sum}, 0);
    d0 = done8_cnt;
    repeat (3) @(negedge clk);
    rst8_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("rst_mid_no_done", done8_cnt - d0, 0);
    run8(8'd3, 8'd4, 1'b0, 9'd7, "after_reset_3_4");

    // exhaustive WIDTH=2 with start held high
    @(negedge clk);
    bus2.start = 1'b1;
    kk = 5'd0;
    bus2.a = kk[1:0]; bus2.b = kk[3:2]; bus2.cin = kk[4];
    last_cyc = 0;
    for (int k = 0; k < 32; k++) begin
      kk = 5'(k);
      exp_w2 = {1'b0, kk[1:0]} + {1'b0, kk[3:2]} + {2'd0, kk[4]};
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        if (bus2.done) begin
          seen = 1;
          break;
        end
        @(negedge clk);
      end
      if (!seen) begin
        check("w2_timeout", 0, 1);
      end else begin
        check("w2_result", {bus2.cout, bus2.sum}, exp_w2);
        if (k > 0) check("w2_spacing", cyc - last_cyc, 4);
        last_cyc = cyc;
      end
      if (k < 31) begin
        kk = 5'(k + 1);
        bus2.a = kk[1:0]; bus2.b = kk[3:2]; bus2.cin = kk[4];
      end else begin
        bus2.start = 1'b0;
      end
      @(negedge clk);
    end

    repeat (6) @(negedge clk);
    check("q8_drained", exp8_q.size(), 0);
    check("q2_drained", exp2_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder: captures two operands and a carry-in on a start request, then adds them LSB-first, one bit per clock, through a single `fulladder` cell with a registered carry. It sits directly upstream of the `fulladder` stage, sequencing operand bits into it and collecting its sum and carry outputs. It is the lab's area-minimal multi-bit adder, giving one result per WIDTH+2 cycles.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 1..32.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request a new addition; sampled only in IDLE.
- `a`  in  WIDTH: operand A; captured on the accepting edge.
- `b`  in  WIDTH: operand B; captured on the accepting edge.
- `cin`  in  1: carry-in; captured on the accepting edge.
- `busy`  out  1: high while bits are being processed (SHIFT).
- `done`  out  1: one-cycle pulse; result is valid.
- `sum`  out  WIDTH: registered result, a+b+cin mod 2^WIDTH.
- `cout`  out  1: registered carry-out of the MSB.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, `start`=1 at an edge: load `a` and `b` into shift registers, load the carry register with `cin`, clear the bit counter, then go to SHIFT. IDLE with `start`=0: stay in IDLE.
- SHIFT, each edge:
  - The `fulladder` sees areg[0], breg[0] and the carry register.
  - Its sum bit enters the partial-sum register at the MSB, which shifts right.
  - Its carry output becomes the new carry register value.
  - areg and breg shift right by one.
  - The counter increments.
- SHIFT, edge that processes bit WIDTH-1: copy the completed partial sum to `sum` and the new carry to `cout`, then go to DONE.
- DONE: `done`=1 for one cycle. The next edge returns to IDLE unconditionally.
- `start` is ignored in SHIFT and DONE. It is not queued, and operand changes have no effect.
- `sum` and `cout` change only on entry to DONE. They hold until the next completion; partial results are never visible.
- Width rules:
  - Counter width is $clog2(WIDTH+1).
  - `cout` is the true carry of the WIDTH-bit sum, so {cout,sum} = a+b+cin exactly.
- Reset values: state IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, and all internal registers 0.
- Reset mid-operation: assertion clears everything immediately, regardless of clock. The operation is abandoned, no `done` is produced, and the previous `sum`/`cout` are lost (they read 0).

## Timing
- Edge 0 is the edge that samples `start`=1 in IDLE.
- Edges 1..WIDTH each process one bit. `busy`=1 from after edge 0 until edge WIDTH.
- After edge WIDTH: `done`=1, and `sum`/`cout` are valid.
- After edge WIDTH+1: `done`=0 and the state is IDLE. The earliest next accepting edge is WIDTH+2.
- `start` held high continuously gives one addition per WIDTH+2 cycles. Each one captures the operands present at its accepting edge.
- WIDTH=1: a single SHIFT cycle; done follows edge 1.
- Release of `rst_n` is synchronised externally by the integrator. The first accepting edge is the first edge after release.

## Structure
- Package `serial_adder_pkg`: state encoding localparams (IDLE, SHIFT, DONE) and the counter-width function.
- Sub-module: one instance of the existing `fulladder` for the per-bit arithmetic. The FSM, shift registers, counter and carry register are in `serial_adder`.

## Test plan
- Reset: hold `rst_n`=0 with `start`=1 and random operands. Required: `busy`=0, `done`=0, `sum`=0, `cout`=0 throughout.
- WIDTH=8, a=8'h5A, b=8'h3C, cin=0. Required: `done` pulses once after edge 8, with sum=8'h96 and cout=0.
- Carry chain, WIDTH=8:
  - a=8'hFF, b=8'h01, cin=0 gives sum=8'h00, cout=1.
  - a=8'hFF, b=8'hFF, cin=1 gives sum=8'hFF, cout=1.
- Ignored start: start a=8'h10, b=8'h20. At edge 3, pulse `start` with a=8'hFF, b=8'hFF. Required: result sum=8'h30, cout=0, and only one `done` pulse.
- Reset mid-SHIFT: assert `rst_n`=0 after edge 4 of an addition. Required: outputs are 0 immediately and no `done` follows. A subsequent start with a=3, b=4 gives sum=7.
- Exhaustive, WIDTH=2: all 32 combinations of a, b and cin with `start` held high back-to-back. Required: {cout,sum}=a+b+cin for each, with `done` spacing of exactly 4 cycles.
